// File: rtl/writeback_queue_pkg.sv
// Shared widths, the hardwired-zero register index and the queued-write record.
package writeback_queue_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_fifo.sv
// Circular buffer of pending register writes with a youngest-first dest search.
// Push is ignored when full and pop is ignored when empty, so count stays in range.
module wbq_fifo
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  wbq_entry_t        push_entry,
  input  logic              pop,
  output wbq_entry_t        head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  input  logic [ADDR_W-1:0] search_key,
  output logic              search_hit,
  output logic [DATA_W-1:0] search_data
);

  wbq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: nothing is visible unless count covers it.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    search_hit  = 1'b0;
    search_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (search_key != REG_ZERO) &&
          (mem[rd_ptr + PTR_W'(i)].dest == search_key)) begin
        search_hit  = 1'b1;
        search_data = mem[rd_ptr + PTR_W'(i)].data;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Arbitrates ALU/LSU results (LSU first) into a queue drained in order to the single rf write port; 1-cycle latency.
// Backpressure via ready=~full; rf_stall holds the head. WRITEBACK_QUEUE_BYPASS_EN adds a 0-cycle path when empty.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = writeback_queue_pkg::ADDR_W,
  parameter int DATA_W = writeback_queue_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_dest,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [ADDR_W-1:0]          lsu_dest,
  input  logic [DATA_W-1:0]          lsu_data,
  input  logic                       rf_stall,
  output logic                       rf_write_enable,
  output logic [ADDR_W-1:0]          rf_dest,
  output logic [DATA_W-1:0]          rf_data,
  input  logic [ADDR_W-1:0]          lookup_src,
  output logic                       lookup_hit,
  output logic [DATA_W-1:0]          lookup_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  wbq_entry_t in_entry;
  wbq_entry_t head;
  logic       full;
  logic       empty;
  logic       lsu_xfer;
  logic       alu_xfer;
  logic       xfer;
  logic       bypass;
  logic       push;

  // Readies drop during reset even though count is already zero.
  assign lsu_ready = ~reset & ~full;
  assign alu_ready = ~reset & ~full & ~lsu_valid;
  assign lsu_xfer  = lsu_valid & lsu_ready;
  assign alu_xfer  = alu_valid & alu_ready;
  assign xfer      = lsu_xfer | alu_xfer;

  always_comb begin
    in_entry.dest = lsu_xfer ? lsu_dest : alu_dest;
    in_entry.data = lsu_xfer ? lsu_data : alu_data;
  end

`ifdef WRITEBACK_QUEUE_BYPASS_EN
  assign bypass = xfer & (in_entry.dest != REG_ZERO) & empty & ~rf_stall;
`else
  assign bypass = 1'b0;
`endif

  // x0 writes are acknowledged and discarded.
  assign push = xfer & (in_entry.dest != REG_ZERO) & ~bypass;

  wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (in_entry),
    .pop         (~rf_stall),
    .head        (head),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .search_key  (lookup_src),
    .search_hit  (lookup_hit),
    .search_data (lookup_data)
  );

  always_comb begin
    rf_write_enable = bypass | (~empty & ~rf_stall);
    rf_dest         = '0;
    rf_data         = '0;
    if (bypass) begin
      rf_dest = in_entry.dest;
      rf_data = in_entry.data;
    end else if (!empty) begin
      rf_dest = head.dest;
      rf_data = head.data;
    end
  end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Buffers writeback results from the ALU and load/store unit (LSU) and serialises them onto the register file's single write port (write_enable, dest, data_in).
- Sits directly upstream of the register file, between the execute/memory stages and the register write port.
- Provides a forwarding lookup so decode can read results that are queued but not yet written.

Parameters:
- DEPTH, 4: number of queue entries; power of two, minimum 2.
- ADDR_W, 5: register index width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle
- alu_dest  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  LSU result accepted this cycle
- lsu_dest  in  ADDR_W  LSU destination register
- lsu_data  in  DATA_W  LSU result
- rf_stall  in  1  register write port unavailable this cycle
- rf_write_enable  out  1  write strobe to register file
- rf_dest  out  ADDR_W  write index to register file
- rf_data  out  DATA_W  write data to register file
- lookup_src  in  ADDR_W  register index probed by decode
- lookup_hit  out  1  a pending write to lookup_src exists
- lookup_data  out  DATA_W  data of the youngest pending write to lookup_src
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-high, and clears all state.
- Reset values: count=0, queue empty, rf_write_enable=0, rf_dest=0, rf_data=0, lookup_hit=0, lookup_data=0, alu_ready=0, lsu_ready=0 while reset is asserted.
- Reset mid-operation discards all pending writes; no rf write occurs in the reset cycle.
- Arbitration: at most one enqueue per cycle, fixed priority with LSU over ALU.
  - lsu_ready = ~full.
  - alu_ready = ~full & ~lsu_valid.
  - full means count==DEPTH, evaluated on registered count. A pop in the same cycle does not open a slot.
- Transfer: a transfer occurs on valid & ready.
  - A transfer with dest==0 is accepted but not stored (x0 is hardwired).
  - Stored entries capture {dest, data} at the clock edge.
- Drain:
  - While count>0: rf_write_enable=1, rf_dest/rf_data = head entry (combinational from storage).
  - Pop occurs at the edge when count>0 and ~rf_stall.
  - count>0 with rf_stall=1: rf_write_enable is forced to 0 and the head is held.
  - count==0: rf_write_enable=0; rf_dest and rf_data are 0.
- Latency: an accepted result appears on rf_* in the cycle after acceptance (1 cycle), and is written at the next edge if not stalled.
- Simultaneous push and pop: count is unchanged; both pointers advance. Pointers wrap modulo DEPTH.
- Ordering: writes drain strictly in acceptance order. Two queued writes to the same register drain oldest first.
- Lookup (combinational):
  - Searches stored entries from youngest to oldest; reports the first entry whose dest==lookup_src.
  - lookup_src==0 never hits.
  - On a miss, lookup_data=0.
  - A head entry being popped this cycle still hits.
  - The current-cycle incoming transfer is not visible to lookup.
- Invariant: count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: WRITEBACK_QUEUE_BYPASS_EN.
- Defined:
  - When count==0, ~rf_stall, and a non-zero-dest transfer occurs, the transfer drives rf_* combinationally in the same cycle and is not stored (0-cycle latency).
  - A transfer that hits rf_stall=1 or a non-empty queue is stored as normal.
- Undefined: every transfer is stored; latency is always at least 1 cycle.

Decomposition:
- Shared package writeback_queue_pkg:
  - ADDR_W and DATA_W defaults;
  - REG_ZERO constant (0);
  - typedef wbq_entry_t {dest[ADDR_W], data[DATA_W]}.
- One sub-module, wbq_fifo: storage array, read/write pointers, count, full/empty flags, and a youngest-first search port. Arbitration, the drain gate and the bypass path stay in the top module.

Test Plan:
- Reset and single push: reset mid-stream with 3 entries queued -> count=0, rf_write_enable=0 immediately, no writes after release. Then lsu push dest=5 data=0xDEADBEEF -> next cycle rf_write_enable=1, rf_dest=5, rf_data=0xDEADBEEF; count returns to 0 after the edge.
- Arbitration: alu_valid=lsu_valid=1 (alu dest=3, lsu dest=4) -> lsu_ready=1, alu_ready=0. ALU accepted next cycle; drain order 4 then 3.
- Full and stall: rf_stall=1 with 4 pushes (dests 1..4) -> count=4, both ready=0, rf_write_enable=0. Release stall -> writes 1,2,3,4 on consecutive cycles.
- x0 drop: push dest=0 data=0x55 -> ready=1, count stays 0, no rf write; lookup_src=0 -> lookup_hit=0.
- Forwarding: with rf_stall=1, queue dest=7/0x11 then dest=7/0x22; lookup_src=7 -> hit=1, data=0x22. After the first pop, still 0x22. After the second pop -> hit=0, data=0.
- Bypass: with WRITEBACK_QUEUE_BYPASS_EN, empty queue, alu push dest=9/0xA5 -> same-cycle rf_write_enable=1, rf_dest=9, count stays 0. Without the macro, the write appears 1 cycle later.
